vx_sfu_lane_splitter: RTL and testbench
=======================================

VX_SFU_LANE_SPLITTER -- requirements
Module: VX_sfu_lane_splitter

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4: threads per warp request.
REQ-002 SHALL have parameter NUM_LANES, default 2: lanes per output packet; NUM_THREADS divisible by NUM_LANES.
REQ-003 SHALL have parameter XLEN, default 32: operand width.
REQ-004 SHALL derive NUM_PKTS = NUM_THREADS/NUM_LANES and PID_WIDTH = max(1, clog2(NUM_PKTS)).
REQ-005 SHALL have ports clk (in, 1, sole clock) and reset (in, 1); one clock; reset is synchronous and active-high.
REQ-006 SHALL have in_valid (in, 1), in_ready (out, 1): request handshake.
REQ-007 SHALL have in_uuid (in, UUID_WIDTH), in_wid (in, NW_WIDTH), in_pc (in, XLEN), in_op_type (in, 4), in_rd (in, NR_BITS), in_wb (in, 1): request sideband.
REQ-008 SHALL have in_tmask (in, NUM_THREADS), in_rs1_data and in_rs2_data (in, NUM_THREADS*XLEN each): per-thread operands, thread i at bits [i*XLEN +: XLEN].
REQ-009 SHALL have out_valid (out, 1), out_ready (in, 1): packet handshake.
REQ-010 SHALL have out_uuid, out_wid, out_pc, out_op_type, out_rd, out_wb (out, widths as inputs): held sideband.
REQ-011 SHALL have out_tmask (out, NUM_LANES), out_rs1_data and out_rs2_data (out, NUM_LANES*XLEN each): lane slice of the current packet.
REQ-012 SHALL have out_pid (out, PID_WIDTH), out_sop (out, 1), out_eop (out, 1): packet index, first packet, last packet.

Function
REQ-013 SHALL hold one request in internal registers; FSM states IDLE and BUSY.
REQ-014 SHALL drive in_ready = (state==IDLE) || (out_valid && out_ready && out_eop).
REQ-015 SHALL capture all in_* fields on in_valid && in_ready and enter BUSY the next cycle; out_valid asserts exactly 1 cycle after acceptance.
REQ-016 SHALL drive out_valid = (state==BUSY); all out_* are functions of held registers and the pid register only (no combinational path from in_* to out_*).
REQ-017 SHALL present group g as threads [g*NUM_LANES +: NUM_LANES] of held tmask/rs1/rs2, with out_pid = g.
REQ-018 SHALL set the pid on acceptance to the lowest group with a nonzero tmask slice; groups with all-zero slices are skipped and never emitted.
REQ-019 SHALL assert out_sop on the first emitted packet of a request only.
REQ-020 SHALL assert out_eop when no higher group has a nonzero slice.
REQ-021 SHALL, on out_valid && out_ready && !out_eop, advance pid to the next higher nonzero group.
REQ-022 SHALL, on out_valid && out_ready && out_eop: if in_valid, capture the new request (back-to-back, no bubble) and remain BUSY; else return to IDLE.
REQ-023 SHALL, for an all-zero in_tmask, emit exactly one packet: pid 0, tmask 0, sop=1, eop=1.
REQ-024 SHALL hold every out_* stable while out_valid && !out_ready.
REQ-025 SHALL emit at most NUM_PKTS packets per request, pids strictly increasing.
REQ-026 SHALL, when NUM_PKTS==1, emit one packet per request with pid 0, sop=eop=1.

Reset
REQ-027 SHALL on reset force state IDLE, pid 0, out_valid 0, in_ready 1 the following cycle; held data registers need no reset.
REQ-028 SHALL on reset asserted mid-request (BUSY) abandon that request; no further packets from it are emitted.

Verification
REQ-029 Full mask: tmask=4'b1111, rs1 = {4,3,2,1}, out_ready=1 -> pkt pid0 tmask 2'b11 rs1 {2,1} sop=1 eop=0; next cycle pid1 tmask 2'b11 rs1 {4,3} sop=0 eop=1; in_ready low for the first packet's cycle only.
REQ-030 Skip: tmask=4'b1100 -> single packet pid1 tmask 2'b11 sop=1 eop=1; tmask=4'b0010 -> single packet pid0 tmask 2'b10 sop=1 eop=1.
REQ-031 Empty: tmask=4'b0000 -> single packet pid0 tmask 2'b00 sop=1 eop=1, uuid preserved.
REQ-032 Backpressure: out_ready=0 for 3 cycles on pid0 of 4'b1111 -> out_* unchanged all 3 cycles, in_ready=0, then pid1 after release.
REQ-033 Back-to-back: two requests (uuid 5, 6, tmask 4'b1111) with in_valid continuous, out_ready=1 -> 4 packets on 4 consecutive cycles, pids 0,1,0,1, uuids 5,5,6,6, no idle cycle.
REQ-034 Reset mid-request: reset pulse while presenting pid0 of 4'b1111 -> out_valid=0 next cycle, in_ready=1, no pid1 packet ever appears.

Source files
------------

// File: rtl/vx_sfu_lane_splitter.sv
// Splits one warp-wide SFU request into lane-sized packets, skipping empty thread groups.
// One request is held at a time; a new one is taken in the same cycle the last packet leaves.
module vx_sfu_lane_splitter #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned UUID_WIDTH  = 44,
  parameter int unsigned NW_WIDTH    = 2,
  parameter int unsigned NR_BITS     = 5,
  localparam int unsigned NUM_PKTS   = NUM_THREADS / NUM_LANES,
  localparam int unsigned PID_WIDTH  = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [UUID_WIDTH-1:0]        in_uuid,
  input  logic [NW_WIDTH-1:0]          in_wid,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [3:0]                   in_op_type,
  input  logic [NR_BITS-1:0]           in_rd,
  input  logic                         in_wb,
  input  logic [NUM_THREADS-1:0]       in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]  in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0]  in_rs2_data,

  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [UUID_WIDTH-1:0]        out_uuid,
  output logic [NW_WIDTH-1:0]          out_wid,
  output logic [XLEN-1:0]              out_pc,
  output logic [3:0]                   out_op_type,
  output logic [NR_BITS-1:0]           out_rd,
  output logic                         out_wb,
  output logic [NUM_LANES-1:0]         out_tmask,
  output logic [NUM_LANES*XLEN-1:0]    out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]    out_rs2_data,
  output logic [PID_WIDTH-1:0]         out_pid,
  output logic                         out_sop,
  output logic                         out_eop
);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic                        state_q, state_d;
  logic [PID_WIDTH-1:0]        pid_q, pid_d;
  logic                        sop_q, sop_d;

  logic [UUID_WIDTH-1:0]       uuid_q, uuid_d;
  logic [NW_WIDTH-1:0]         wid_q, wid_d;
  logic [XLEN-1:0]             pc_q, pc_d;
  logic [3:0]                  op_type_q, op_type_d;
  logic [NR_BITS-1:0]          rd_q, rd_d;
  logic                        wb_q, wb_d;
  logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs1_d;
  logic [NUM_THREADS*XLEN-1:0] rs2_q, rs2_d;

  logic [NUM_PKTS-1:0]         held_nz;
  logic [NUM_PKTS-1:0]         in_nz;
  logic [PID_WIDTH-1:0]        in_first_pid;
  logic [PID_WIDTH-1:0]        next_pid;
  logic                        has_next;
  logic                        in_fire;
  logic                        out_fire;

  // Per-group "any thread active" flags for the held request and the incoming one.
  always_comb begin
    held_nz = '0;
    in_nz   = '0;
    for (int g = 0; g < int'(NUM_PKTS); g++) begin
      held_nz[g] = |tmask_q[g*NUM_LANES +: NUM_LANES];
      in_nz[g]   = |in_tmask[g*NUM_LANES +: NUM_LANES];
    end
  end

  // Scanning downwards leaves the lowest matching group; an empty mask falls back to group 0.
  always_comb begin
    in_first_pid = '0;
    for (int g = int'(NUM_PKTS) - 1; g >= 0; g--) begin
      if (in_nz[g]) begin
        in_first_pid = PID_WIDTH'(g);
      end
    end
  end

  always_comb begin
    has_next = 1'b0;
    next_pid = pid_q;
    for (int g = int'(NUM_PKTS) - 1; g >= 0; g--) begin
      if (held_nz[g] && (g > int'(pid_q))) begin
        has_next = 1'b1;
        next_pid = PID_WIDTH'(g);
      end
    end
  end

  always_comb begin
    out_valid = (state_q == StBusy);
    out_eop   = !has_next;
    out_sop   = sop_q;
    out_pid   = pid_q;
    out_fire  = out_valid && out_ready;
    in_ready  = (state_q == StIdle) || (out_fire && out_eop);
    in_fire   = in_valid && in_ready;
  end

  always_comb begin
    out_uuid    = uuid_q;
    out_wid     = wid_q;
    out_pc      = pc_q;
    out_op_type = op_type_q;
    out_rd      = rd_q;
    out_wb      = wb_q;
    out_tmask    = '0;
    out_rs1_data = '0;
    out_rs2_data = '0;
    for (int g = 0; g < int'(NUM_PKTS); g++) begin
      if (pid_q == PID_WIDTH'(g)) begin
        out_tmask    = tmask_q[g*NUM_LANES +: NUM_LANES];
        out_rs1_data = rs1_q[g*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        out_rs2_data = rs2_q[g*NUM_LANES*XLEN +: NUM_LANES*XLEN];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    sop_d     = sop_q;
    uuid_d    = uuid_q;
    wid_d     = wid_q;
    pc_d      = pc_q;
    op_type_d = op_type_q;
    rd_d      = rd_q;
    wb_d      = wb_q;
    tmask_d   = tmask_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    if (in_fire) begin
      state_d   = StBusy;
      pid_d     = in_first_pid;
      sop_d     = 1'b1;
      uuid_d    = in_uuid;
      wid_d     = in_wid;
      pc_d      = in_pc;
      op_type_d = in_op_type;
      rd_d      = in_rd;
      wb_d      = in_wb;
      tmask_d   = in_tmask;
      rs1_d     = in_rs1_data;
      rs2_d     = in_rs2_data;
    end else if (out_fire) begin
      if (out_eop) begin
        state_d = StIdle;
      end else begin
        pid_d = next_pid;
        sop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pid_q   <= '0;
      sop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      sop_q   <= sop_d;
    end
  end

  // Payload only matters while BUSY, so it carries no reset.
  always_ff @(posedge clk) begin
    uuid_q    <= uuid_d;
    wid_q     <= wid_d;
    pc_q      <= pc_d;
    op_type_q <= op_type_d;
    rd_q      <= rd_d;
    wb_q      <= wb_d;
    tmask_q   <= tmask_d;
    rs1_q     <= rs1_d;
    rs2_q     <= rs2_d;
  end

endmodule

// File: tb/tb_vx_sfu_lane_splitter.sv
// Scoreboard bench for vx_sfu_lane_splitter with 4 threads split into 2-lane packets.
module tb_vx_sfu_lane_splitter;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [43:0]  in_uuid;
  logic [1:0]   in_wid;
  logic [31:0]  in_pc;
  logic [3:0]   in_op_type;
  logic [4:0]   in_rd;
  logic         in_wb;
  logic [3:0]   in_tmask;
  logic [127:0] in_rs1_data, in_rs2_data;
  logic         out_valid, out_ready;
  logic [43:0]  out_uuid;
  logic [1:0]   out_wid;
  logic [31:0]  out_pc;
  logic [3:0]   out_op_type;
  logic [4:0]   out_rd;
  logic         out_wb;
  logic [1:0]   out_tmask;
  logic [63:0]  out_rs1_data, out_rs2_data;
  logic [0:0]   out_pid;
  logic         out_sop, out_eop;

  vx_sfu_lane_splitter dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_uuid      (in_uuid),
    .in_wid       (in_wid),
    .in_pc        (in_pc),
    .in_op_type   (in_op_type),
    .in_rd        (in_rd),
    .in_wb        (in_wb),
    .in_tmask     (in_tmask),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_uuid     (out_uuid),
    .out_wid      (out_wid),
    .out_pc       (out_pc),
    .out_op_type  (out_op_type),
    .out_rd       (out_rd),
    .out_wb       (out_wb),
    .out_tmask    (out_tmask),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_pid      (out_pid),
    .out_sop      (out_sop),
    .out_eop      (out_eop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [43:0] uuid;
    logic [31:0] pc;
    logic [0:0]  pid;
    logic [1:0]  tmask;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        sop;
    logic        eop;
  } pkt_t;

  pkt_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   fire_cnt = 0;

  bit          have_snap = 0;
  logic [63:0] snap_rs1;
  logic [63:0] snap_ctl;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference split: one packet per non-empty 2-thread group, or a lone pid-0 packet if none.
  task automatic push_exp(input logic [43:0] uuid, input logic [31:0] pc, input logic [3:0] tm,
                          input logic [127:0] r1, input logic [127:0] r2);
    pkt_t p;
    bit   first = 1;
    for (int g = 0; g < 2; g++) begin
      if (tm[g*2 +: 2] != 2'b00) begin
        p.uuid  = uuid;
        p.pc    = pc;
        p.pid   = 1'(g);
        p.tmask = tm[g*2 +: 2];
        p.rs1   = r1[g*64 +: 64];
        p.rs2   = r2[g*64 +: 64];
        p.sop   = first;
        p.eop   = 1'b1;
        for (int h = g + 1; h < 2; h++) begin
          if (tm[h*2 +: 2] != 2'b00) p.eop = 1'b0;
        end
        exp_q.push_back(p);
        first = 0;
      end
    end
    if (first) begin
      p.uuid  = uuid;
      p.pc    = pc;
      p.pid   = 1'b0;
      p.tmask = 2'b00;
      p.rs1   = r1[63:0];
      p.rs2   = r2[63:0];
      p.sop   = 1'b1;
      p.eop   = 1'b1;
      exp_q.push_back(p);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && !out_ready) begin
      check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (have_snap) begin
        check_eq("stall_rs1", out_rs1_data, snap_rs1);
        check_eq("stall_ctl", {out_uuid[15:0], out_pc[15:0], 27'd0, out_pid, out_tmask,
                               out_sop, out_eop}, snap_ctl);
      end else begin
        have_snap = 1;
        snap_rs1  = out_rs1_data;
        snap_ctl  = {out_uuid[15:0], out_pc[15:0], 27'd0, out_pid, out_tmask, out_sop, out_eop};
      end
    end else begin
      have_snap = 0;
    end
    if (out_valid && out_ready) begin
      fire_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_pkt", {20'd0, out_uuid}, 64'hffff_ffff_ffff_ffff);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        check_eq("pid", {63'd0, out_pid}, {63'd0, e.pid});
        check_eq("tmask", {62'd0, out_tmask}, {62'd0, e.tmask});
        check_eq("rs1", out_rs1_data, e.rs1);
        check_eq("rs2", out_rs2_data, e.rs2);
        check_eq("uuid", {20'd0, out_uuid}, {20'd0, e.uuid});
        check_eq("pc", {32'd0, out_pc}, {32'd0, e.pc});
        check_eq("sop", {63'd0, out_sop}, {63'd0, e.sop});
        check_eq("eop", {63'd0, out_eop}, {63'd0, e.eop});
        check_eq("in_ready_fire", {63'd0, in_ready}, {63'd0, e.eop});
      end
    end
  end

  task automatic send(input logic [43:0] uuid, input logic [3:0] tm,
                      input logic [127:0] r1, input logic [127:0] r2);
    bit ok = 0;
    in_valid    = 1'b1;
    in_uuid     = uuid;
    in_pc       = 32'h1000 + uuid[31:0];
    in_tmask    = tm;
    in_rs1_data = r1;
    in_rs2_data = r2;
    push_exp(uuid, 32'h1000 + uuid[31:0], tm, r1, r2);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check_eq("accept_timeout", 64'd0, 64'd1);
    check_eq("valid_latency", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int c0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_uuid     = '0;
    in_wid      = 2'd1;
    in_pc       = '0;
    in_op_type  = 4'd3;
    in_rd       = 5'd7;
    in_wb       = 1'b1;
    in_tmask    = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_pid", {63'd0, out_pid}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_out_valid", {63'd0, out_valid}, 64'd0);

    // Full mask, operands 1..4
    out_ready = 1'b1;
    send(44'd1, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10});
    in_valid = 1'b0;
    drain();

    // Skipped groups and empty mask
    send(44'd2, 4'b1100, {32'd14, 32'd13, 32'd12, 32'd11}, 128'd0);
    in_valid = 1'b0;
    drain();
    send(44'd3, 4'b0010, {32'd24, 32'd23, 32'd22, 32'd21}, 128'd5);
    in_valid = 1'b0;
    drain();
    send(44'h123_4567_89ab, 4'b0000, {32'd34, 32'd33, 32'd32, 32'd31}, 128'd9);
    in_valid = 1'b0;
    drain();

    // Backpressure on the first packet
    out_ready = 1'b0;
    send(44'd7, 4'b1111, {32'd8, 32'd7, 32'd6, 32'd5}, {32'd1, 32'd2, 32'd3, 32'd4});
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("stall_pid", {63'd0, out_pid}, 64'd0);
    out_ready = 1'b1;
    drain();

    // Back-to-back requests with no bubble
    send(44'd5, 4'b1111, {32'd54, 32'd53, 32'd52, 32'd51}, 128'd0);
    c0 = fire_cnt;
    send(44'd6, 4'b1111, {32'd64, 32'd63, 32'd62, 32'd61}, 128'd1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("b2b_count", 64'(fire_cnt - c0), 64'd4);
    check_eq("b2b_idle_after", {63'd0, out_valid}, 64'd0);
    drain();

    // Reset while pid0 is presented
    out_ready = 1'b0;
    send(44'd8, 4'b1111, {32'd84, 32'd83, 32'd82, 32'd81}, 128'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_quiet", {63'd0, out_valid}, 64'd0);

    // Random masks and operands, continuous requests
    for (int i = 0; i < 10; i++) begin
      send(44'(100 + i), 4'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    end
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
